// File: rtl/ripple_carry_adder_4bit.sv
// ripple_carry_adder_4bit
//   Registered 4-bit ripple-carry adder with carry-in and a valid bit.
//   The result is {Carry,Sum} = A + B + Cin. Ovf flags two's-complement
//   overflow. All outputs appear one clock after their operands are sampled.
//
// Ports
//   clk        system clock, rising-edge active
//   rst        synchronous reset, active-high; clears all outputs
//   A, B       4-bit addends (unsigned, also read as two's complement)
//   Cin        carry into bit 0
//   in_valid   A/B/Cin carry a real operation this cycle
//   Sum        registered sum bits [3:0]
//   Carry      registered carry out of bit 3
//   Ovf        registered signed overflow (carry into bit 3 ^ carry out of bit 3)
//   out_valid  Sum/Carry/Ovf hold the result of a valid operation
module ripple_carry_adder_4bit (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    input  logic       in_valid,
    output logic [3:0] Sum,
    output logic       Carry,
    output logic       Ovf,
    output logic       out_valid
);

    // c[i] is the carry into bit i; c[4] is the carry out of bit 3.
    logic [4:0] c;
    logic [3:0] s;
    logic       ovf_comb;

    assign c[0] = Cin;

    full_adder fa0 (.a(A[0]), .b(B[0]), .ci(c[0]), .s(s[0]), .co(c[1]));
    full_adder fa1 (.a(A[1]), .b(B[1]), .ci(c[1]), .s(s[1]), .co(c[2]));
    full_adder fa2 (.a(A[2]), .b(B[2]), .ci(c[2]), .s(s[2]), .co(c[3]));
    full_adder fa3 (.a(A[3]), .b(B[3]), .ci(c[3]), .s(s[3]), .co(c[4]));

    assign ovf_comb = c[3] ^ c[4];

    // Result registers load every cycle regardless of in_valid; consumers
    // qualify them with out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            Sum       <= '0;
            Carry     <= 1'b0;
            Ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            Sum       <= s;
            Carry     <= c[4];
            Ovf       <= ovf_comb;
            out_valid <= in_valid;
        end
    end

endmodule

// full_adder
//   One-bit full adder used as a ripple stage.
//   a, b   operand bits
//   ci     carry in
//   s      sum bit
//   co     carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    // p is the propagate term: the incoming carry passes through when a != b.
    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

// File: tb/tb_ripple_carry_adder_4bit.sv
module tb_ripple_carry_adder_4bit;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] A;
    logic [3:0] B;
    logic       Cin;
    logic       in_valid;
    logic [3:0] Sum;
    logic       Carry;
    logic       Ovf;
    logic       out_valid;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    ripple_carry_adder_4bit dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .in_valid  (in_valid),
        .Sum       (Sum),
        .Carry     (Carry),
        .Ovf       (Ovf),
        .out_valid (out_valid)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic, unsigned for {Carry,Sum},
    // signed range check for Ovf. Packed as {out_valid, Ovf, Carry, Sum}.
    function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b,
                                         input logic ci, input logic v, input logic r);
        int unsigned u;
        int sa, sb, st;
        logic [7:0] res;
        if (r) return 8'h00;
        u  = int'(a) + int'(b) + int'(ci);
        sa = a[3] ? int'(a) - 16 : int'(a);
        sb = b[3] ? int'(b) - 16 : int'(b);
        st = sa + sb + int'(ci);
        res = '0;
        res[3:0] = u[3:0];
        res[4]   = u[4];
        res[5]   = (st > 7) || (st < -8);
        res[6]   = v;
        return res;
    endfunction

    function automatic logic [7:0] observed();
        return {1'b0, out_valid, Ovf, Carry, Sum};
    endfunction

    // One cycle: drive operands away from the edge, then sample #1 after it.
    task automatic step(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic ci, input logic v, input logic r);
        @(negedge clk);
        A = a; B = b; Cin = ci; in_valid = v; rst = r;
        @(posedge clk);
        #1;
        check(tag, observed(), model(a, b, ci, v, r));
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       ci;
        logic [3:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    vec_t vecs[9] = '{
        '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0},
        '{4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0},
        '{4'b0001, 4'b0010, 1'b0, 4'b0011, 1'b0, 1'b0},
        '{4'b0010, 4'b0101, 1'b0, 4'b0111, 1'b0, 1'b0},
        '{4'b0011, 4'b0100, 1'b1, 4'b1000, 1'b0, 1'b1},
        '{4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1},
        '{4'b1111, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b0},
        '{4'b0110, 4'b1011, 1'b1, 4'b0010, 1'b1, 1'b0},
        '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0}
    };

    initial begin
        logic [7:0] exp;
        logic [8:0] combo;

        // Reset with a live operation present: it must be discarded.
        rst = 1'b1; in_valid = 1'b1; A = 4'hF; B = 4'hF; Cin = 1'b1;
        step("reset0", 4'hF, 4'hF, 1'b1, 1'b1, 1'b1);
        step("reset1", 4'hF, 4'hF, 1'b1, 1'b1, 1'b1);

        // Directed vectors back-to-back, checked against literal expectations.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            A = vecs[i].a; B = vecs[i].b; Cin = vecs[i].ci; in_valid = 1'b1; rst = 1'b0;
            @(posedge clk);
            #1;
            exp = {1'b0, 1'b1, vecs[i].ov, vecs[i].co, vecs[i].s};
            check($sformatf("vec%0d", i), observed(), exp);
        end

        // Bubble: one invalid cycle, then valid again.
        step("bubble_pre", 4'h3, 4'h4, 1'b0, 1'b1, 1'b0);
        step("bubble",     4'h5, 4'h6, 1'b0, 1'b0, 1'b0);
        step("bubble_post", 4'h7, 4'h7, 1'b1, 1'b1, 1'b0);

        // Reset pulse mid-stream, then the next valid op is the first result.
        step("mid_pre",   4'h9, 4'h9, 1'b0, 1'b1, 1'b0);
        step("mid_rst",   4'hF, 4'hF, 1'b1, 1'b1, 1'b1);
        step("mid_idle",  4'h2, 4'h3, 1'b0, 1'b0, 1'b0);
        step("mid_first", 4'h8, 4'h8, 1'b1, 1'b1, 1'b0);

        // Exhaustive sweep of all 512 operand combinations.
        for (int unsigned k = 0; k < 512; k++) begin
            combo = k[8:0];
            step("exh", combo[3:0], combo[7:4], combo[8], 1'b1, 1'b0);
        end

        // Random stream with random valid and occasional reset.
        for (int unsigned k = 0; k < 400; k++) begin
            step("rand", 4'($urandom), 4'($urandom), 1'($urandom),
                 1'($urandom), ($urandom_range(0, 15) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
